ifu_imem_resp: RTL and testbench

Instruction-memory responder that answers the fetch requests issued by the PC/fetch front end of the RISC-V NPC core. It accepts one word-fetch request at a time over a valid/ready handshake and waits a configurable number of cycles to model SRAM latency. It then returns the 32-bit instruction, or an error flag, over a second valid/ready handshake. A side load port preloads the program image.

---
 rtl/ifu_imem_resp_if.sv | 31 +++
 rtl/ifu_imem_resp.sv | 133 +++++++++++++
 tb/tb_ifu_imem_resp.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_imem_resp_if.sv
// Fetch request/response channel between the fetch front end (master)
// and the instruction-memory responder (slave).
interface ifu_imem_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_inst;
   logic        resp_err;

   modport master (
      output req_valid,
      output req_addr,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_inst,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_inst,
      output resp_err
   );
endinterface

// File: rtl/ifu_imem_resp.sv
// Instruction-memory responder: one outstanding word fetch, fixed modelled
// SRAM latency, range/alignment fault detection and a side preload port.
module ifu_imem_resp #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   ifu_imem_resp_if.slave    bus,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
);

   if (LATENCY < 1) begin : g_bad_latency
      $error("ifu_imem_resp: LATENCY must be >= 1");
   end
   if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("ifu_imem_resp: DEPTH_WORDS must be a power of two >= 2");
   end
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("ifu_imem_resp: BASE_ADDR must be word aligned");
   end

   localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [32:0]     SPAN     = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_inst_q, resp_inst_d;
   logic              resp_err_q, resp_err_d;

   logic [31:0]       mem [DEPTH_WORDS];

   logic [31:0]       offset;
   logic              fault;
   logic [ADDR_W-1:0] rd_idx;

   // Base is word aligned, so the offset's low bits are the address's low
   // bits; the 33-bit compare keeps the upper bound from wrapping past 2^32.
   assign offset = addr_q - BASE_ADDR;
   assign fault  = (offset[1:0] != 2'b00)
                || (addr_q < BASE_ADDR)
                || ({1'b0, offset} >= SPAN);
   assign rd_idx = offset[ADDR_W+1:2];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      resp_valid_d = resp_valid_q;
      resp_inst_d  = resp_inst_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               resp_inst_d  = fault ? 32'h0000_0000 : mem[rd_idx];
               resp_err_d   = fault;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_inst_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         resp_valid_q <= resp_valid_d;
         resp_inst_q  <= resp_inst_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Program image survives reset; a same-edge lookup sees the old word.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_inst  = resp_inst_q;
   assign bus.resp_err   = resp_err_q;

   a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid_q && !bus.resp_ready) |=>
         (resp_valid_q && $stable(resp_inst_q) && $stable(resp_err_q)));

   a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == S_IDLE) && resp_valid_q));

endmodule

// File: tb/tb_ifu_imem_resp.sv
// Directed bench: one LATENCY=1 responder for function/fault/collision/reset
// cases and one LATENCY=3 responder for latency and back-pressure.
module tb_ifu_imem_resp;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        la_en, lb_en;
   logic [9:0]  la_addr, lb_addr;
   logic [31:0] la_data, lb_data;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          c0, c1, cx;

   ifu_imem_resp_if ia ();
   ifu_imem_resp_if ib ();

   ifu_imem_resp #(.LATENCY(1)) dut_a (
      .clk      (clk),
      .rst_n    (rst_a),
      .bus      (ia),
      .load_en  (la_en),
      .load_addr(la_addr),
      .load_data(la_data)
   );

   ifu_imem_resp #(.LATENCY(3)) dut_b (
      .clk      (clk),
      .rst_n    (rst_b),
      .bus      (ib),
      .load_en  (lb_en),
      .load_addr(lb_addr),
      .load_data(lb_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic a_load(input logic [9:0] idx, input logic [31:0] data);
      la_en = 1'b1; la_addr = idx; la_data = data;
      @(posedge clk); #1;
      la_en = 1'b0;
   endtask

   // Entered and left 1 time unit after a rising edge; resp_ready held high.
   task automatic a_fetch(input logic [31:0] addr, input logic [31:0] exp_inst,
                          input logic exp_err, input bit collide,
                          input logic [31:0] col_data, input string tag,
                          output int acc_cyc);
      ia.req_valid  = 1'b1;
      ia.req_addr   = addr;
      ia.resp_ready = 1'b1;
      check({tag, "_req_ready"}, ia.req_ready, 1);
      @(posedge clk); #1;
      acc_cyc      = cyc;
      ia.req_valid = 1'b0;
      check({tag, "_wait_valid"}, ia.resp_valid, 0);
      if (collide) begin
         la_en   = 1'b1;
         la_addr = 10'((addr - 32'h8000_0000) >> 2);
         la_data = col_data;
      end
      @(posedge clk); #1;
      la_en = 1'b0;
      check({tag, "_valid"}, ia.resp_valid, 1);
      check({tag, "_inst"}, ia.resp_inst, exp_inst);
      check({tag, "_err"}, ia.resp_err, exp_err);
      $display("fetch %s addr=%h inst=%h err=%b", tag, addr, ia.resp_inst, ia.resp_err);
      @(posedge clk); #1;
      check({tag, "_done_valid"}, ia.resp_valid, 0);
      check({tag, "_done_ready"}, ia.req_ready, 1);
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      la_en = 1'b0; la_addr = '0; la_data = '0;
      lb_en = 1'b0; lb_addr = '0; lb_data = '0;
      ia.req_valid = 1'b0; ia.req_addr = '0; ia.resp_ready = 1'b0;
      ib.req_valid = 1'b0; ib.req_addr = '0; ib.resp_ready = 1'b0;

      #12;
      check("rst_a_req_ready", ia.req_ready, 1);
      check("rst_a_resp_valid", ia.resp_valid, 0);
      check("rst_a_resp_inst", ia.resp_inst, 0);
      check("rst_a_resp_err", ia.resp_err, 0);
      check("rst_b_req_ready", ib.req_ready, 1);
      check("rst_b_resp_valid", ib.resp_valid, 0);
      @(posedge clk); #1;
      rst_a = 1'b1; rst_b = 1'b1;

      a_load(10'd0, 32'h0000_0093);
      a_load(10'd1, 32'h0010_0113);
      a_load(10'd5, 32'hAAAA_AAAA);
      a_load(10'd1023, 32'h1234_5678);
      lb_en = 1'b1; lb_addr = 10'd2; lb_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      lb_en = 1'b0;

      // Back-to-back fetches at LATENCY+2 spacing
      a_fetch(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b0, 0, "w0", c0);
      a_fetch(32'h8000_0004, 32'h0010_0113, 1'b0, 1'b0, 0, "w1", c1);
      check("accept_gap", c1 - c0, 3);

      a_fetch(32'h8000_0002, 32'h0, 1'b1, 1'b0, 0, "misalign", cx);
      a_fetch(32'h7FFF_FFFC, 32'h0, 1'b1, 1'b0, 0, "below", cx);
      a_fetch(32'h8000_1000, 32'h0, 1'b1, 1'b0, 0, "above", cx);
      a_fetch(32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 0, "top", cx);
      a_fetch(32'h8000_0FFC, 32'h1234_5678, 1'b0, 1'b0, 0, "last", cx);

      a_fetch(32'h8000_0014, 32'hAAAA_AAAA, 1'b0, 1'b1, 32'h5555_5555, "collide", cx);
      a_fetch(32'h8000_0014, 32'h5555_5555, 1'b0, 1'b0, 0, "refetch", cx);

      // Reset abort while a request sits in WAIT, with a held fault flag
      a_fetch(32'h8000_0002, 32'h0, 1'b1, 1'b0, 0, "pre_abort", cx);
      ia.req_valid = 1'b1; ia.req_addr = 32'h8000_0004;
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      check("abort_wait_ready", ia.req_ready, 0);
      check("abort_held_err", ia.resp_err, 1);
      rst_a = 1'b0;
      #1;
      check("abort_valid", ia.resp_valid, 0);
      check("abort_err", ia.resp_err, 0);
      check("abort_ready", ia.req_ready, 1);
      @(posedge clk); #1;
      rst_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_no_stale", ia.resp_valid, 0);
      end
      $display("reset abort issued");
      a_fetch(32'h8000_0000, 32'h0000_0093, 1'b0, 1'b0, 0, "post_abort", cx);

      // Hold-off: req_valid stays high through a stalled response
      ia.req_valid = 1'b1; ia.req_addr = 32'h8000_0000; ia.resp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ho_valid", ia.resp_valid, 1);
      check("ho_inst", ia.resp_inst, 32'h0000_0093);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("ho_stall_ready", ia.req_ready, 0);
         check("ho_stall_valid", ia.resp_valid, 1);
      end
      ia.req_addr = 32'h8000_0004; ia.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("ho_hs_valid", ia.resp_valid, 0);
      check("ho_hs_ready", ia.req_ready, 1);
      @(posedge clk); #1;
      check("ho_acc_ready", ia.req_ready, 0);
      ia.req_valid = 1'b0;
      @(posedge clk); #1;
      check("ho2_valid", ia.resp_valid, 1);
      check("ho2_inst", ia.resp_inst, 32'h0010_0113);
      @(posedge clk); #1;
      check("ho2_done_valid", ia.resp_valid, 0);
      $display("hold-off sequence complete");

      // LATENCY=3 with 4 cycles of back-pressure
      ib.req_valid = 1'b1; ib.req_addr = 32'h8000_0008; ib.resp_ready = 1'b0;
      check("b_req_ready", ib.req_ready, 1);
      @(posedge clk); #1;
      ib.req_valid = 1'b0;
      check("b_t0_valid", ib.resp_valid, 0);
      for (int i = 1; i < 3; i++) begin
         @(posedge clk); #1;
         check("b_wait_valid", ib.resp_valid, 0);
         check("b_wait_ready", ib.req_ready, 0);
      end
      @(posedge clk); #1;
      check("b_t3_valid", ib.resp_valid, 1);
      check("b_t3_inst", ib.resp_inst, 32'hDEAD_BEEF);
      check("b_t3_err", ib.resp_err, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("b_stall_valid", ib.resp_valid, 1);
         check("b_stall_inst", ib.resp_inst, 32'hDEAD_BEEF);
         check("b_stall_ready", ib.req_ready, 0);
      end
      ib.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("b_done_valid", ib.resp_valid, 0);
      check("b_done_ready", ib.req_ready, 1);
      check("b_done_inst", ib.resp_inst, 32'hDEAD_BEEF);
      $display("fetch b addr=80000008 inst=%h err=%b", ib.resp_inst, ib.resp_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
